// File: rtl/lc3b_types.sv
// LC-3b shared types: opcodes, register/offset widths and the decoded-instruction
// field bundle produced by ir_field_decode.
package lc3b_types;

   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   typedef logic [2:0]  lc3b_reg;
   typedef logic [5:0]  lc3b_offset6;
   typedef logic [8:0]  lc3b_offset9;
   typedef logic [10:0] lc3b_offset11;
   typedef logic [7:0]  lc3b_byte;
   typedef logic [15:0] lc3b_word;

   localparam lc3b_reg R7 = 3'b111;

   typedef struct packed {
      lc3b_opcode   opcode;
      lc3b_reg      dest;
      lc3b_reg      src1;
      lc3b_reg      src2;
      logic         imm;
      logic [4:0]   imm5;
      lc3b_word     imm4;
      lc3b_offset6  offset6;
      lc3b_offset9  offset9;
      lc3b_offset11 offset11;
      lc3b_byte     trap8;
      logic         bit11;
      logic         bit4;
   } lc3b_ir_fields;

endpackage

// File: rtl/ir_field_decode.sv
// Combinational LC-3b field extractor; TRAP and JSR/JSRR write the link register,
// so dest is forced to R7 for those opcodes.
module ir_field_decode
   import lc3b_types::*;
(
   input  lc3b_word      i_word,
   output lc3b_ir_fields o_fields
);

   lc3b_opcode w_opcode;

   assign w_opcode = lc3b_opcode'(i_word[15:12]);

   always_comb begin
      o_fields          = '0;
      o_fields.opcode   = w_opcode;
      o_fields.dest     = ((w_opcode == op_trap) || (w_opcode == op_jsr)) ? R7 : i_word[11:9];
      o_fields.src1     = i_word[8:6];
      o_fields.src2     = i_word[2:0];
      o_fields.imm      = i_word[5];
      o_fields.imm5     = i_word[4:0];
      o_fields.imm4     = {12'h000, i_word[3:0]};
      o_fields.offset6  = i_word[5:0];
      o_fields.offset9  = i_word[8:0];
      o_fields.offset11 = i_word[10:0];
      o_fields.trap8    = i_word[7:0];
      o_fields.bit11    = i_word[11];
      o_fields.bit4     = i_word[4];
   end

endmodule

// File: rtl/ir_queue.sv
// LC-3b instruction buffer: DEPTH-entry register FIFO of {pc, instr} with a decoded head.
// Optional IR_QUEUE_BYPASS_EN lets an instruction reach the outputs combinationally when empty.
module ir_queue
   import lc3b_types::*;
#(
   parameter int DEPTH = 4,
   parameter int PC_W  = 16
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [15:0]                  in_instr,
   input  logic [PC_W-1:0]              in_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [PC_W-1:0]              out_pc,
   output lc3b_opcode                   opcode,
   output lc3b_reg                      dest,
   output lc3b_reg                      src1,
   output lc3b_reg                      src2,
   output logic                         imm,
   output logic [4:0]                   imm5,
   output lc3b_word                     imm4,
   output lc3b_offset6                  offset6,
   output lc3b_offset9                  offset9,
   output lc3b_offset11                 offset11,
   output lc3b_byte                     trap8,
   output logic                         bit11,
   output logic                         bit4,
   input  logic                         flush,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [15:0]     r_instr [DEPTH];
   logic [PC_W-1:0] r_pc    [DEPTH];
   logic [PTR_W-1:0] r_wptr, r_rptr;
   logic [CNT_W-1:0] r_count;

   logic            w_bypass;
   logic            w_push, w_pop, w_wr, w_rd;
   lc3b_word        w_head_word;
   logic [PC_W-1:0] w_head_pc;
   lc3b_ir_fields   w_fields;

`ifdef IR_QUEUE_BYPASS_EN
   assign w_bypass = (r_count == '0) && in_valid && !flush;
`else
   assign w_bypass = 1'b0;
`endif

   assign in_ready  = (r_count < CNT_W'(DEPTH)) && !flush;
   assign out_valid = (r_count != '0) || w_bypass;
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;
   // A bypassed instruction taken the same cycle never touches storage.
   assign w_wr      = w_push && !(w_bypass && out_ready);
   assign w_rd      = w_pop && !w_bypass;

   always_comb begin
      w_head_word = '0;
      w_head_pc   = '0;
      if (w_bypass) begin
         w_head_word = in_instr;
         w_head_pc   = in_pc;
      end else if (r_count != '0) begin
         w_head_word = r_instr[r_rptr];
         w_head_pc   = r_pc[r_rptr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr)
            r_wptr <= (r_wptr == PTR_W'(DEPTH-1)) ? '0 : r_wptr + 1'b1;
         if (w_rd)
            r_rptr <= (r_rptr == PTR_W'(DEPTH-1)) ? '0 : r_rptr + 1'b1;
         if (w_wr && !w_rd)
            r_count <= r_count + 1'b1;
         else if (w_rd && !w_wr)
            r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr && !flush) begin
         r_instr[r_wptr] <= in_instr;
         r_pc[r_wptr]    <= in_pc;
      end
   end

   ir_field_decode u_decode (
      .i_word   (w_head_word),
      .o_fields (w_fields)
   );

   assign out_pc   = w_head_pc;
   assign opcode   = w_fields.opcode;
   assign dest     = w_fields.dest;
   assign src1     = w_fields.src1;
   assign src2     = w_fields.src2;
   assign imm      = w_fields.imm;
   assign imm5     = w_fields.imm5;
   assign imm4     = w_fields.imm4;
   assign offset6  = w_fields.offset6;
   assign offset9  = w_fields.offset9;
   assign offset11 = w_fields.offset11;
   assign trap8    = w_fields.trap8;
   assign bit11    = w_fields.bit11;
   assign bit4     = w_fields.bit4;
   assign count    = r_count;

endmodule

// File: tb/tb_ir_queue.sv
// Randomized bench for ir_queue against a queue-based reference model, plus directed
// reset, decode, flush and bypass cases.
module tb_ir_queue;
   import lc3b_types::*;

   localparam int DEPTH = 4;
   localparam int PC_W  = 16;
   localparam int CW    = $clog2(DEPTH+1);

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
   logic [15:0]     in_instr = 16'h0;
   logic [PC_W-1:0] in_pc = '0;
   logic            in_ready, out_valid;
   logic [PC_W-1:0] out_pc;
   lc3b_opcode      opcode;
   lc3b_reg         dest, src1, src2;
   logic            imm, bit11, bit4;
   logic [4:0]      imm5;
   lc3b_word        imm4;
   lc3b_offset6     offset6;
   lc3b_offset9     offset9;
   lc3b_offset11    offset11;
   lc3b_byte        trap8;
   logic [CW-1:0]   count;

   always #5 clk = ~clk;

   ir_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .opcode(opcode), .dest(dest), .src1(src1), .src2(src2), .imm(imm), .imm5(imm5),
      .imm4(imm4), .offset6(offset6), .offset9(offset9), .offset11(offset11),
      .trap8(trap8), .bit11(bit11), .bit4(bit4), .flush(flush), .count(count)
   );

   int total = 0;
   int bad   = 0;
   logic [31:0] model_q[$];   // {pc, instr}, head at index 0

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Field packing straight from the LC-3b instruction format.
   function automatic logic [127:0] fields_of(input logic [15:0] w);
      logic [2:0] d;
      d = ((w[15:12] == 4'hF) || (w[15:12] == 4'h4)) ? 3'd7 : w[11:9];
      return {w[15:12], d, w[8:6], w[2:0], w[5], w[4:0], 12'h000, w[3:0],
              w[5:0], w[8:0], w[10:0], w[7:0], w[11], w[4]};
   endfunction

   function automatic logic [127:0] dut_fields();
      return {opcode, dest, src1, src2, imm, imm5, imm4, offset6, offset9,
              offset11, trap8, bit11, bit4};
   endfunction

   // One clock: drive inputs, check outputs against the model, then advance the model.
   task automatic cycle(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                        input logic ordy, input logic fl);
      logic        byp, exp_valid, exp_ready;
      logic [31:0] head;
      @(negedge clk);
      in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
      #1;
      byp = 1'b0;
`ifdef IR_QUEUE_BYPASS_EN
      byp = (model_q.size() == 0) && v && !fl;
`endif
      exp_valid = (model_q.size() != 0) || byp;
      exp_ready = (model_q.size() < DEPTH) && !fl;
      head = 32'h0;
      if (byp) head = {pc, ins};
      else if (model_q.size() != 0) head = model_q[0];
      check("count", 128'(count), 128'(model_q.size()));
      check("out_valid", 128'(out_valid), 128'(exp_valid));
      check("in_ready", 128'(in_ready), 128'(exp_ready));
      check("out_pc", 128'(out_pc), 128'(head[31:16]));
      check("fields", dut_fields(), fields_of(head[15:0]));
      @(posedge clk);
      if (fl) begin
         model_q.delete();
      end else if (byp) begin
         if (!ordy) model_q.push_back({pc, ins});
      end else begin
         if (exp_valid && ordy) void'(model_q.pop_front());
         if (v && exp_ready) model_q.push_back({pc, ins});
      end
      #2;
   endtask

   initial begin
      // Reset with stale inputs present.
      in_valid = 1'b1; in_instr = 16'hF025; in_pc = 16'h3000; out_ready = 1'b1;
      #12;
      check("rst_count", 128'(count), 128'(0));
      check("rst_valid", 128'(out_valid), 128'(0));
      check("rst_dest", 128'(dest), 128'(0));
      check("rst_ready", 128'(in_ready), 128'(1));
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      rst_n = 1'b1;

      // Fill to DEPTH with out_ready low.
      cycle(1'b1, 16'h1042, 16'h3000, 1'b0, 1'b0);
      cycle(1'b1, 16'h5A25, 16'h3002, 1'b0, 1'b0);
      cycle(1'b1, 16'hF025, 16'h3004, 1'b0, 1'b0);
      cycle(1'b1, 16'h4801, 16'h3006, 1'b0, 1'b0);
      check("full_count", 128'(count), 128'(4));
      check("full_ready", 128'(in_ready), 128'(0));
      check("add_op", 128'(opcode), 128'(op_add));
      check("add_dest", 128'(dest), 128'(0));
      check("add_src1", 128'(src1), 128'(1));
      check("add_src2", 128'(src2), 128'(2));
      check("add_imm", 128'(imm), 128'(0));
      cycle(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0);  // full: push refused, pop 1042
      check("imm_bit", 128'(imm), 128'(1));
      check("imm5", 128'(imm5), 128'(5));
      cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      check("trap_op", 128'(opcode), 128'(op_trap));
      check("trap_dest", 128'(dest), 128'(7));
      check("trap8", 128'(trap8), 128'(8'h25));
      cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      check("jsr_op", 128'(opcode), 128'(op_jsr));
      check("jsr_dest", 128'(dest), 128'(7));
      check("jsr_bit11", 128'(bit11), 128'(1));
      check("jsr_off11", 128'(offset11), 128'(11'h001));
      check("jsr_pc", 128'(out_pc), 128'(16'h3006));

      // Hold occupancy at 2 with simultaneous push and pop; exercises pointer wrap.
      cycle(1'b1, 16'h2111, 16'h4000, 1'b0, 1'b0);
      check("cnt2", 128'(count), 128'(2));
      for (int i = 0; i < 10; i++)
         cycle(1'b1, 16'($urandom), 16'(16'h4002 + 2*i), 1'b1, 1'b0);
      check("steady_cnt", 128'(count), 128'(2));

      // Flush wins over a concurrent push and pop.
      cycle(1'b1, 16'h6123, 16'h5000, 1'b0, 1'b0);
      cycle(1'b1, 16'h7123, 16'h5002, 1'b1, 1'b1);
      check("flush_cnt", 128'(count), 128'(0));
      check("flush_valid", 128'(out_valid), 128'(0));

      // Empty queue, push with consumer ready.
      cycle(1'b1, 16'h1042, 16'h6000, 1'b1, 1'b0);
`ifdef IR_QUEUE_BYPASS_EN
      check("byp_cnt", 128'(count), 128'(0));
`else
      check("nobyp_cnt", 128'(count), 128'(1));
      check("nobyp_valid", 128'(out_valid), 128'(1));
`endif

      // Asynchronous reset between edges with entries buffered.
      cycle(1'b1, 16'h3333, 16'h6002, 1'b0, 1'b0);
      cycle(1'b1, 16'h3334, 16'h6004, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_count", 128'(count), 128'(0));
      check("arst_valid", 128'(out_valid), 128'(0));
      model_q.delete();
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic.
      for (int i = 0; i < 2000; i++)
         cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 30) == 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ir_queue.md
Name: ir_queue

Overview:
- Parametrised instruction buffer for the LC-3b datapath. It replaces the single load-enabled instruction register.
- Holds up to DEPTH fetched instruction words, each with its fetch PC, in a FIFO with valid/ready on both sides.
- Decodes the head entry into the standard LC-3b fields for the control unit and datapath.
- Supports a flush for branch, jump, trap and JSR redirects, so fetch can run ahead of execute.

Parameters:
- DEPTH, 4, number of buffered entries; legal range 1..16; need not be a power of two.
- PC_W, 16, width of the PC stored alongside each instruction.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  queue accepts; asserted iff count < DEPTH and flush = 0
- in_instr  in  16  fetched instruction word
- in_pc  in  PC_W  PC of in_instr
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes the head entry this cycle
- out_pc  out  PC_W  PC of the head entry
- opcode  out  lc3b_opcode  head[15:12]
- dest  out  lc3b_reg  head[11:9]; forced to 3'b111 when opcode is op_trap or op_jsr
- src1  out  lc3b_reg  head[8:6]
- src2  out  lc3b_reg  head[2:0]
- imm  out  1  head[5]
- imm5  out  5  head[4:0]
- imm4  out  lc3b_word  head[3:0], zero-extended
- offset6  out  lc3b_offset6  head[5:0]
- offset9  out  lc3b_offset9  head[8:0]
- offset11  out  lc3b_offset11  head[10:0]
- trap8  out  lc3b_byte  head[7:0]
- bit11  out  1  head[11] (the JSR/JSRR select bit)
- bit4  out  1  head[4]
- flush  in  1  discard all entries
- count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (rst_n low, asynchronous): count = 0; read and write pointers = 0; out_valid = 0.
- Reset is honoured mid-operation; all buffered entries are lost.
- While out_valid = 0, every decoded field and out_pc reads 0, with no R7 override (opcode 0000 = op_br).
- Push: occurs when in_valid and in_ready are both high at a rising edge. The entry is written at wptr and wptr advances.
- Pop: occurs when out_valid and out_ready are both high at a rising edge. rptr advances.
- Pointer wrap: a pointer advances from DEPTH-1 to 0. Wrap is explicit compare, not modulo-2^n.
- Simultaneous push and pop: both occur and count is unchanged.
  - When count = DEPTH, in_ready is low, so a same-cycle pop does not admit a push; the push is accepted next cycle.
- Latency: an instruction pushed at edge N is visible on out_valid and the decoded fields after edge N (one cycle).
- Full: count = DEPTH, in_ready = 0; in_instr is ignored.
- Empty: out_valid = 0; out_ready is ignored.
- Flush: at the edge where flush is high, count, wptr and rptr all become 0.
  - flush has priority over push and pop; neither takes effect in that cycle.
  - in_ready is low combinationally while flush is high.
- Decoded fields: a pure function of the head entry; no registering beyond the storage.
- Storage: registers only; no RAM inference.

Optional Feature:
- Macro: IR_QUEUE_BYPASS_EN.
- Defined: when count = 0 and in_valid = 1 and flush = 0:
  - out_valid = 1, and decode/out_pc reflect in_instr/in_pc combinationally.
  - If out_ready is also high, the instruction is consumed without being written and count stays 0.
  - If out_ready is low, it is written normally.
- Undefined: one-cycle latency always; no combinational in-to-out path.

Decomposition:
- lc3b_types package, existing: lc3b_opcode, lc3b_reg, lc3b_offset6/9/11, lc3b_byte, lc3b_word.
- lc3b_types additions: constant lc3b_reg R7 = 3'b111; typedef lc3b_ir_fields as a packed struct of all decoded outputs.
- Sub-module ir_field_decode: combinational, input lc3b_word, output lc3b_ir_fields. It holds the R7 override and is reusable by the trace monitor.
- ir_queue: pointers, count, storage, handshake, plus one ir_field_decode instance.

Test Plan:
- Reset with stale data -> out_valid = 0, count = 0, dest = 0, in_ready = 1; reassert rst_n between edges -> immediate clear.
- DEPTH = 4, push 16'h1042, 16'h5A25, 16'hF025, 16'h4801 with out_ready = 0 -> count = 4, in_ready = 0 after 4th edge.
  - Then pop: opcode = op_add, dest = 0, src1 = 1, src2 = 2, imm = 0.
  - Next head 5A25: imm = 1, imm5 = 5.
- Head 16'hF025 -> opcode op_trap, dest = 7, trap8 = 8'h25; head 16'h4801 -> op_jsr, dest = 7, bit11 = 1, offset11 = 11'h001.
- count = 2 with push and pop in the same cycle for 10 cycles -> count stays 2 and FIFO order is preserved.
  - DEPTH = 3 build: pointers wrap 2 -> 0 with correct out_pc sequence.
- count = 3, flush together with in_valid and out_ready -> next cycle count = 0, out_valid = 0; neither the push nor the pop took effect.
- Bypass build, empty, push 16'h1042 with out_ready = 1 -> out_valid = 1 in the same cycle, count remains 0.
  - Non-bypass build: out_valid rises one cycle later.
